// File: rtl/dac_sample_interp.sv
// Sample FIFO plus linear interpolator feeding the MASH DSM DAC input.
// Emits 2^INTERP_LOG2 interpolated values per input sample, one every TICK_DIV clocks.
module dac_sample_interp #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INTERP_LOG2 = 4,
    parameter int TICK_DIV    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [15:0]                  out,
    output logic                         out_stb,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    input  logic                         underrun_clr
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int PROD_W = 18 + INTERP_LOG2;

    localparam logic [DIV_W-1:0]       DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [INTERP_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [LVL_W-1:0]       LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PRIME,
        S_RUN,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [15:0]            a_q, a_d;
    logic [15:0]            b_q, b_d;
    logic [INTERP_LOG2-1:0] phase_q, phase_d;
    logic [15:0]            out_q, out_d;
    logic                   out_stb_q, out_stb_d;
    logic                   underrun_q, underrun_d;

    logic [15:0]            mem_q [FIFO_DEPTH];
    logic [15:0]            rd_data;
    logic                   tick;
    logic                   push;
    logic                   pop;
    logic                   level_nonzero;
    logic                   underrun_set;

    logic signed [PROD_W-1:0] a_ext, b_ext, phase_ext, prod;
    logic [15:0]              interp;

    assign tick          = (div_cnt_q == DIV_LAST);
    assign s_ready       = (level_q != LEVEL_FULL);
    assign push          = s_valid && s_ready;
    assign level_nonzero = (level_q != '0);
    assign rd_data       = mem_q[rd_ptr_q];

    assign out        = out_q;
    assign out_stb    = out_stb_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

    // NOTE: sample storage carries no reset; the level counter alone decides
    // which entries are valid, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Everything is widened so (B-A)*phase and the arithmetic shift cannot lose bits;
    // the final sum always lies between A and B, so the 16-bit truncation is exact.
    always_comb begin
        a_ext     = {{(PROD_W-16){a_q[15]}}, a_q};
        b_ext     = {{(PROD_W-16){b_q[15]}}, b_q};
        phase_ext = {{(PROD_W-INTERP_LOG2){1'b0}}, phase_q};
        prod      = (b_ext - a_ext) * phase_ext;
        interp    = 16'(a_ext + (prod >>> INTERP_LOG2));
    end

    // NOTE: every output of this block gets a default first, so paths that do not
    // assign a signal hold its register value instead of inferring a latch.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        phase_d      = phase_q;
        out_d        = out_q;
        pop          = 1'b0;
        underrun_set = 1'b0;

        if (tick) begin
            case (state_q)
                S_EMPTY: begin
                    out_d = '0;
                    if (level_nonzero) begin
                        pop     = 1'b1;
                        a_d     = rd_data;
                        state_d = S_PRIME;
                    end
                end
                S_PRIME: begin
                    out_d = a_q;
                    if (level_nonzero) begin
                        pop     = 1'b1;
                        b_d     = rd_data;
                        phase_d = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    out_d   = interp;
                    phase_d = phase_q + INTERP_LOG2'(1);
                    if (phase_q == PHASE_LAST) begin
                        a_d     = b_q;
                        phase_d = '0;
                        if (level_nonzero) begin
                            pop = 1'b1;
                            b_d = rd_data;
                        end else begin
                            underrun_set = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    out_d = a_q;
                    if (level_nonzero) begin
                        pop     = 1'b1;
                        b_d     = rd_data;
                        phase_d = '0;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        out_stb_d  = tick;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A new underrun wins over a simultaneous clear request.
        underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
    end

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            div_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            phase_q    <= '0;
            out_q      <= '0;
            out_stb_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            a_q        <= a_d;
            b_q        <= b_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
            out_stb_q  <= out_stb_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_interp.sv
// Directed bench for dac_sample_interp: an integer-arithmetic model checked every cycle,
// plus literal expectations for the ramp, rounding, extreme-range and FIFO-full cases.
module tb_dac_sample_interp;

    localparam int FIFO_DEPTH  = 4;
    localparam int INTERP_LOG2 = 4;
    localparam int TICK_DIV    = 8;
    localparam int NSTEP       = 1 << INTERP_LOG2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] out;
    logic        out_stb;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    dac_sample_interp #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .INTERP_LOG2 (INTERP_LOG2),
        .TICK_DIV    (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .out          (out),
        .out_stb      (out_stb),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    int got [64];

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending samples; pos = -2 nothing loaded, -1 first sample only,
    // 0..NSTEP-1 position inside the current A->B segment, NSTEP holding the last sample.
    int mq [$];
    int m_div   = 0;
    int m_pos   = -2;
    int m_a     = 0;
    int m_b     = 0;
    int m_out   = 0;
    bit m_stb   = 1'b0;
    bit m_under = 1'b0;

    function automatic int floor_div(int n, int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_div = 0; m_pos = -2; m_a = 0; m_b = 0; m_out = 0;
                m_stb = 1'b0; m_under = 1'b0;
            end else begin
                int  lvl;
                bit  tk, psh, set;
                lvl = mq.size();
                tk  = (m_div == TICK_DIV - 1);
                psh = s_valid && (lvl < FIFO_DEPTH);
                set = 1'b0;
                if (tk) begin
                    if (m_pos == -2) begin
                        m_out = 0;
                        if (lvl > 0) begin m_a = mq.pop_front(); m_pos = -1; end
                    end else if (m_pos == -1) begin
                        m_out = m_a;
                        if (lvl > 0) begin m_b = mq.pop_front(); m_pos = 0; end
                    end else if (m_pos == NSTEP) begin
                        m_out = m_a;
                        if (lvl > 0) begin m_b = mq.pop_front(); m_pos = 0; end
                    end else begin
                        m_out = m_a + floor_div((m_b - m_a) * m_pos, NSTEP);
                        if (m_pos == NSTEP - 1) begin
                            m_a = m_b;
                            if (lvl > 0) begin m_b = mq.pop_front(); m_pos = 0; end
                            else begin set = 1'b1; m_pos = NSTEP; end
                        end else begin
                            m_pos = m_pos + 1;
                        end
                    end
                end
                if (set) m_under = 1'b1;
                else if (underrun_clr) m_under = 1'b0;
                if (psh) mq.push_back(int'($signed(s_data)));
                m_stb = tk;
                m_div = (m_div + 1) % TICK_DIV;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("out",        int'($signed(out)), m_out);
                check("out_stb",    int'(out_stb),      int'(m_stb));
                check("underrun",   int'(underrun),     int'(m_under));
                check("fifo_level", int'(fifo_level),   mq.size());
                check("s_ready",    int'(s_ready),      int'(mq.size() < FIFO_DEPTH));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_out",      int'($signed(out)), 0);
        check("rst_level",    int'(fifo_level),   0);
        check("rst_ready",    int'(s_ready),      1);
        check("rst_underrun", int'(underrun),     0);
        check("rst_stb",      int'(out_stb),      0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_sample(int v);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                s_data  = 16'(v);
                s_valid = 1'b1;
                done    = 1'b1;
            end
        end
        if (!done) check("push_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_stb(output int val);
        bit seen = 1'b0;
        val = 0;
        for (int i = 0; i < 4 * TICK_DIV && !seen; i++) begin
            @(negedge clk);
            if (out_stb) begin
                seen = 1'b1;
                val  = int'($signed(out));
            end
        end
        if (!seen) check("stb_timeout", 0, 1);
    endtask

    task automatic collect(int n);
        for (int i = 0; i < n; i++) wait_stb(got[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int gap;
        int exp_neg3 [16] = '{0, -1, -1, -1, -1, -1, -2, -2, -2, -2, -2, -3, -3, -3, -3, -3};

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Idle after reset: zero output, strobe period of TICK_DIV clocks.
        do_reset();
        wait_stb(v);
        check("idle_out", v, 0);
        gap = 0;
        for (int i = 1; i <= 4 * TICK_DIV && gap == 0; i++) begin
            @(negedge clk);
            if (out_stb) gap = i;
        end
        check("stb_period", gap, TICK_DIV);

        // Ramp 0 -> 1600, then hold with underrun.
        do_reset();
        push_sample(0);
        push_sample(1600);
        collect(19);
        check("ramp_empty", got[0], 0);
        check("ramp_prime", got[1], 0);
        for (int p = 0; p < NSTEP; p++) check($sformatf("ramp_p%0d", p), got[2 + p], 100 * p);
        check("ramp_hold", got[18], 1600);
        check("ramp_underrun", int'(underrun), 1);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("underrun_cleared", int'(underrun), 0);

        // Negative slope: arithmetic shift floors toward -inf.
        do_reset();
        push_sample(0);
        push_sample(-3);
        push_sample(-3);
        collect(35);
        for (int p = 0; p < NSTEP; p++) check($sformatf("neg3_p%0d", p), got[2 + p], exp_neg3[p]);
        check("neg3_seg2", got[18], -3);
        check("neg3_hold", got[34], -3);

        // Full-scale ramp, interrupted mid-run by reset, then replayed.
        do_reset();
        push_sample(-32768);
        push_sample(32767);
        collect(12);
        do_reset();
        push_sample(-32768);
        push_sample(32767);
        collect(19);
        check("full_p0",   got[2],  -32768);
        check("full_p8",   got[10], -1);
        check("full_p15",  got[17], 28671);
        check("full_hold", got[18], 32767);

        // FIFO full: s_valid held high between ticks.
        do_reset();
        wait_stb(v);
        s_data  = 16'h0123;
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("full_level", int'(fifo_level), 4);
        check("full_ready", int'(s_ready),    0);
        wait_stb(v);
        check("pop_level", int'(fifo_level), 3);
        check("pop_ready", int'(s_ready),    1);
        s_valid = 1'b0;
        @(negedge clk);
        check("after_pop_level", int'(fifo_level), 3);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
